// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer family: mode encodings and
// a width helper that stays valid for degenerate channel counts.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;  // forced select by sel
  localparam logic MODE_RR  = 1'b1;  // round-robin arbitration

  // Width of a channel index; never returns 0 so ports stay legal.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requesting index at or
// after ptr, wrapping modulo NUM_CH. Equivalent to rotate / priority-encode /
// un-rotate, written as a bounded search so non-power-of-2 sizes just work.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_vld
);

  int idx;

  // Scan ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel, W-bit stream multiplexer with a registered output stage.
// Selects one channel per cycle, either forced by sel or round-robin, and
// forwards its word through a single valid/ready output register.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int  NUM_CH = 4,
  parameter int  DATA_W = 32,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  logic                  load_en;
  logic [2**SEL_W-1:0]   valid_pad;
  logic [SEL_W-1:0]      rr_idx;
  logic                  rr_vld;
  logic [SEL_W-1:0]      grant_idx;
  logic                  grant_vld;
  logic [DATA_W-1:0]     grant_data;
  logic [SEL_W-1:0]      ptr;

  // The register can accept a word when empty or when it drains this cycle.
  assign load_en = ~out_valid | out_ready;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_pick (
    .req       (in_valid),
    .ptr       (ptr),
    .grant_idx (rr_idx),
    .grant_vld (rr_vld)
  );

  // Forced-select grant: sel values past the last channel index into zero padding.
  always_comb begin
    valid_pad               = '0;
    valid_pad[NUM_CH-1:0]   = in_valid;
    if (mode == MODE_RR) begin
      grant_idx = rr_idx;
      grant_vld = rr_vld;
    end else begin
      grant_idx = sel;
      grant_vld = valid_pad[sel];
    end
  end

  // Data select for the granted channel.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Ready goes only to the granted channel, and never while reset is held.
  always_comb begin
    in_ready = '0;
    if (!rst && grant_vld && load_en) in_ready[grant_idx] = 1'b1;
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all control and data state is reset here; the output word is
    // cleared too, so a reset mid-stream drops the word in flight.
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      // NOTE: non-blocking assignments keep all register updates on this edge
      // independent of statement order.
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant_idx;
        ptr       <= (grant_idx == SEL_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: a 4-channel instance for the main
// behaviour and a 3-channel instance for the non-power-of-2 corner cases.
module tb_rr_stream_mux;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 4-channel instance
  logic        mode     = MODE_RR;
  logic [1:0]  sel      = '0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data  = '0;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready = 1'b1;

  // 3-channel instance
  logic        mode3     = MODE_SEL;
  logic [1:0]  sel3      = '0;
  logic [2:0]  in_valid3 = '0;
  logic [23:0] in_data3  = '0;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_ready3 = 1'b1;

  rr_stream_mux #(.NUM_CH(4), .DATA_W(8)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  rr_stream_mux #(.NUM_CH(3), .DATA_W(8)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_ready (out_ready3)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    mode      = MODE_RR;
    in_valid  = 4'hF;
    in_data   = 32'hA3A2A1A0;
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected %b", in_ready, 4'b0000);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (out_data !== 8'h00 || out_ch !== 2'd0) begin
      n_fail++; $display("FAIL reset_out_word: got data %h ch %0d expected 00 ch 0", out_data, out_ch);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL release_in_ready: got %b expected %b", in_ready, 4'b0001);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'hA0) begin
      n_fail++;
      $display("FAIL first_grant: got v%b ch %0d data %h expected v1 ch 0 data a0",
               out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_rr_fairness();
    logic [1:0] exp_ch;
    logic [7:0] exp_data;
    for (int k = 1; k <= 8; k++) begin
      exp_ch   = 2'(k % 4);
      exp_data = 8'hA0 + 8'(k % 4);
      n_checks++;
      if (in_ready !== (4'b0001 << exp_ch)) begin
        n_fail++; $display("FAIL rr_in_ready[%0d]: got %b expected %b", k, in_ready, 4'b0001 << exp_ch);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_ch !== exp_ch || out_data !== exp_data) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: got v%b ch %0d data %h expected v1 ch %0d data %h",
                 k, out_valid, out_ch, out_data, exp_ch, exp_data);
      end
    end
  endtask

  task automatic test_forced_select();
    // Register holds ch0 / a0 from the last fairness step.
    mode     = MODE_SEL;
    sel      = 2'd2;
    in_valid = 4'b1011;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL sel_no_grant_ready: got %b expected 0000", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL sel_no_grant_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (out_data !== 8'hA0 || out_ch !== 2'd0) begin
      n_fail++; $display("FAIL sel_hold_word: got data %h ch %0d expected a0 ch 0", out_data, out_ch);
    end
    in_valid = 4'b0100;
    in_data  = 32'hA3_55_A1_A0;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++; $display("FAIL sel_grant_ready: got %b expected 0100", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h55 || out_ch !== 2'd2) begin
      n_fail++;
      $display("FAIL sel_grant_word: got v%b data %h ch %0d expected v1 data 55 ch 2",
               out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_backpressure();
    // Register full with 55/ch2; pointer now at 3.
    out_ready = 1'b0;
    mode      = MODE_RR;
    in_valid  = 4'hF;
    in_data   = 32'hA3A2A1A0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h55 || out_ch !== 2'd2) begin
        n_fail++;
        $display("FAIL stall[%0d]: got ready %b v%b data %h ch %0d expected 0000 v1 55 ch 2",
                 k, in_ready, out_valid, out_data, out_ch);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b1000) begin
      n_fail++; $display("FAIL drain_ready: got %b expected 1000", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'hA3) begin
      n_fail++;
      $display("FAIL drain_refill: got v%b ch %0d data %h expected v1 ch 3 data a3",
               out_valid, out_ch, out_data);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'hA0) begin
      n_fail++;
      $display("FAIL wrap_after_3: got v%b ch %0d data %h expected v1 ch 0 data a0",
               out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_mid_reset();
    // Register full (ch0); pointer at 1. Assert reset between edges.
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL async_clear: got v%b data %h ch %0d expected v0 00 ch 0",
               out_valid, out_data, out_ch);
    end
    tick();
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_hold_ready: got %b expected 0000", in_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL restart_ready: got %b expected 0001", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'hA0) begin
      n_fail++;
      $display("FAIL restart_ch0: got v%b ch %0d data %h expected v1 ch 0 data a0",
               out_valid, out_ch, out_data);
    end
    tick();
    n_checks++;
    if (out_ch !== 2'd1 || out_data !== 8'hA1) begin
      n_fail++; $display("FAIL restart_ch1: got ch %0d data %h expected ch 1 data a1", out_ch, out_data);
    end
  endtask

  task automatic test_non_pow2();
    logic [1:0] exp_ch;
    mode3      = MODE_SEL;
    sel3       = 2'd3;
    in_valid3  = 3'b111;
    in_data3   = 24'hB2B1B0;
    out_ready3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (in_ready3 !== 3'b000) begin
        n_fail++; $display("FAIL sel3_ready[%0d]: got %b expected 000", k, in_ready3);
      end
      tick();
      n_checks++;
      if (out_valid3 !== 1'b0) begin
        n_fail++; $display("FAIL sel3_valid[%0d]: got %b expected 0", k, out_valid3);
      end
    end
    mode3 = MODE_RR;
    for (int k = 0; k < 5; k++) begin
      exp_ch = 2'(k % 3);
      tick();
      n_checks++;
      if (out_valid3 !== 1'b1 || out_ch3 !== exp_ch || out_data3 !== 8'hB0 + 8'(exp_ch)) begin
        n_fail++;
        $display("FAIL rr3_seq[%0d]: got v%b ch %0d data %h expected v1 ch %0d data %h",
                 k, out_valid3, out_ch3, out_data3, exp_ch, 8'hB0 + 8'(exp_ch));
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_forced_select();
    test_backpressure();
    test_mid_reset();
    test_non_pow2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
